// File: rtl/ls132r_rr_arbiter_8.sv
// ls132r_rr_arbiter_8: round-robin arbiter sharing one resource among 8 requesters.
// A rotating pointer sets priority. Owners may lock the grant for bursts, but only up to
// MAX_HOLD cycles while someone else is waiting. All outputs come straight from flops.
module ls132r_rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] req,
  input  logic [7:0] lock,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [7:0]        gnt_q, gnt_d;
  logic [2:0]        gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [7:0]        masked;
  logic              masked_any;
  logic [2:0]        masked_idx;
  logic [2:0]        req_idx;
  logic              win_valid;
  logic [2:0]        win_idx;
  logic              others;
  logic              keep;

  // Search for a winner: lowest request at or above ptr, else wrap to the lowest request overall.
  always_comb begin
    masked     = req & (8'hFF << ptr_q);
    masked_any = |masked;
    masked_idx = 3'd0;
    req_idx    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (masked[i]) masked_idx = 3'(i);
      if (req[i])    req_idx    = 3'(i);
    end
    win_valid = |req;
    win_idx   = masked_any ? masked_idx : req_idx;
  end

  // Next-state logic: keep a locked owner, or re-arbitrate and hand over on the same edge.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    hold_cnt_d  = hold_cnt_q;
    others      = |(req & ~gnt_q);
    keep        = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d    = BUSY;
          gnt_d      = 8'h01 << win_idx;
          gnt_id_d   = win_idx;
          ptr_d      = win_idx + 3'd1;
          hold_cnt_d = '0;
        end
      end
      BUSY: begin
        keep = req[gnt_id_q] & lock[gnt_id_q] & ~((hold_cnt_q == HOLD_LAST) & others);
        if (keep) begin
          if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (win_valid) begin
          gnt_d      = 8'h01 << win_idx;
          gnt_id_d   = win_idx;
          ptr_d      = win_idx + 3'd1;
          hold_cnt_d = '0;
        end else begin
          state_d    = IDLE;
          gnt_d      = 8'h00;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase

    gnt_valid_d = |gnt_d;
  end

  // State and output registers; an asynchronous reset clears the outputs immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      gnt_q       <= 8'h00;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_ls132r_rr_arbiter_8.sv
// Testbench for ls132r_rr_arbiter_8: directed scenarios plus random traffic,
// all checked against a behavioural model of the round-robin / lock / hold rules.
module tb_ls132r_rr_arbiter_8;

  localparam int MAX_HOLD = 16;

  logic       clock;
  logic       resetn;
  logic [7:0] req;
  logic [7:0] lock;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  int num_checks = 0;
  int num_errors = 0;

  // Reference model state: whether someone owns the grant, who, priority start, cycles held.
  bit m_valid;
  int m_owner;
  int m_ptr;
  int m_hold;

  ls132r_rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req),
    .lock      (lock),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scan from the pointer upward with wrap-around; first requester found wins.
  function automatic int modelWinner(input logic [7:0] r, input int p);
    for (int j = 0; j < 8; j++) begin
      if (r[(p + j) % 8]) return (p + j) % 8;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_valid = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  task automatic modelStep(input logic [7:0] r, input logic [7:0] l);
    int  w;
    bit  others;
    bit  keep;
    keep = 0;
    if (m_valid) begin
      others = (r & ~(8'h01 << m_owner)) != 8'h00;
      keep   = r[m_owner] && l[m_owner] && !((m_hold == MAX_HOLD - 1) && others);
    end
    if (keep) begin
      if (m_hold < MAX_HOLD - 1) m_hold++;
    end else begin
      w = modelWinner(r, m_ptr);
      if (w >= 0) begin
        m_valid = 1;
        m_owner = w;
        m_ptr   = (w + 1) % 8;
        m_hold  = 0;
      end else begin
        m_valid = 0;
        m_hold  = 0;
      end
    end
  endtask

  task automatic compareModel();
    checkOutput("gnt", 32'(gnt), m_valid ? 32'(8'h01 << m_owner) : 32'h0);
    checkOutput("gnt_valid", 32'(gnt_valid), 32'(m_valid));
    if (m_valid) checkOutput("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  // Drive one cycle of inputs, advance the model, and compare just after the edge.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] l);
    req  = r;
    lock = l;
    modelStep(r, l);
    @(posedge clock);
    #1;
    compareModel();
  endtask

  initial begin
    logic [7:0] rnd_req;
    logic [7:0] rnd_lock;

    $display("[TB] starting ls132r_rr_arbiter_8 bench");
    resetn = 1'b0;
    req    = 8'hFF;
    lock   = 8'h00;
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_valid", 32'(gnt_valid), 32'h0);
    checkOutput("reset_gnt_id", 32'(gnt_id), 32'h0);

    // Full rotation with every port requesting and no locks.
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(8'hFF, 8'h00);
    checkOutput("first_after_reset", 32'(gnt), 32'h01);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'hFF, 8'h00);
      checkOutput("rotation", 32'(gnt), 32'(8'h01 << (i % 8)));
    end

    // Grant index 2, then wrap-around behaviour with req=05.
    applyStimulus(8'h04, 8'h00);
    checkOutput("grant_idx2", 32'(gnt), 32'h04);
    applyStimulus(8'h05, 8'h00);
    checkOutput("wrap_to_0", 32'(gnt), 32'h01);
    applyStimulus(8'h05, 8'h00);
    checkOutput("wrap_then_2", 32'(gnt), 32'h04);
    applyStimulus(8'h05, 8'h00);
    checkOutput("wrap_back_0", 32'(gnt), 32'h01);

    // Hold limit: locked port 0 competes with port 3.
    applyStimulus(8'h00, 8'h00);
    checkOutput("idle_valid", 32'(gnt_valid), 32'h0);
    applyStimulus(8'h08, 8'h00);
    for (int i = 0; i < MAX_HOLD; i++) begin
      applyStimulus(8'h09, 8'h01);
      checkOutput("hold_run1", 32'(gnt), 32'h01);
    end
    applyStimulus(8'h09, 8'h01);
    checkOutput("hold_handover", 32'(gnt), 32'h08);
    for (int i = 0; i < MAX_HOLD; i++) begin
      applyStimulus(8'h09, 8'h01);
      checkOutput("hold_run2", 32'(gnt), 32'h01);
    end

    // Lone locked requester is never forced off.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'h01, 8'h01);
      checkOutput("lone_lock", 32'(gnt), 32'h01);
    end
    applyStimulus(8'h00, 8'h01);
    checkOutput("drop_gnt", 32'(gnt), 32'h0);
    checkOutput("drop_valid", 32'(gnt_valid), 32'h0);

    // Asynchronous reset in the middle of a hold.
    for (int i = 0; i < 4; i++) applyStimulus(8'h03, 8'h01);
    #3;
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_gnt", 32'(gnt), 32'h0);
    checkOutput("async_rst_valid", 32'(gnt_valid), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(8'h80, 8'h00);
    checkOutput("post_rst_80", 32'(gnt), 32'h80);
    checkOutput("post_rst_id7", 32'(gnt_id), 32'd7);
    applyStimulus(8'h81, 8'h00);
    checkOutput("ptr_wrap_01", 32'(gnt), 32'h01);

    // Random traffic: mixed dense/sparse requests, locks biased on.
    for (int i = 0; i < 600; i++) begin
      rnd_req  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rnd_req = rnd_req & 8'($urandom);
      if ($urandom_range(0, 15) == 0) rnd_req = 8'h00;
      rnd_lock = ($urandom_range(0, 1) == 1) ? 8'($urandom | $urandom) : 8'h00;
      applyStimulus(rnd_req, rnd_lock);
      checkOutput("onehot", 32'($countones(gnt) <= 1), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
